// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Requester 0 is the execute stage, requester 1 is the load/store address generator.
//   At most one request is granted per cycle. The granted payload is driven onto the ALU,
//   and the ALU result is captured into that requester's one-entry response register.
//
// Build option:
//   ALU_ARBITER_RR_EN  defined   -> round-robin arbitration between contending requesters.
//                      undefined -> fixed priority; requester 0 always wins, no prio state.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_valid_i[i]   request valid (0 = execute, 1 = AGU)
//   req_ready_o[i]   request accepted this cycle (equals grant[i])
//   req_instr_i      2 x INSTR_W one-hot decoded instruction, requester i at [i*INSTR_W +: INSTR_W]
//   req_rs1_v_i      2 x 32 operand rs1, requester i at [i*32 +: 32]
//   req_rs2_v_i      2 x 32 operand rs2
//   req_imm_i        2 x 32 immediate
//   req_tag_i        2 x TAG_W opaque tag
//   resp_valid_o[i]  response register i holds a result
//   resp_ready_i[i]  consumer i takes the response this cycle
//   resp_result_o    2 x 32 captured ALU results
//   resp_tag_o       2 x TAG_W captured tags
//   alu_instr_o      instruction to the ALU, zero when nothing is granted
//   alu_rs1_v_o, alu_rs2_v_o, alu_imm_o  operands to the ALU, zero when nothing is granted
//   alu_result_i     combinational ALU result for the current operands

module alu_arbiter #(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned INSTR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*INSTR_W-1:0] req_instr_i,
  input  logic [63:0]          req_rs1_v_i,
  input  logic [63:0]          req_rs2_v_i,
  input  logic [63:0]          req_imm_i,
  input  logic [2*TAG_W-1:0]   req_tag_i,

  output logic [1:0]           resp_valid_o,
  input  logic [1:0]           resp_ready_i,
  output logic [63:0]          resp_result_o,
  output logic [2*TAG_W-1:0]   resp_tag_o,

  output logic [INSTR_W-1:0]   alu_instr_o,
  output logic [31:0]          alu_rs1_v_o,
  output logic [31:0]          alu_rs2_v_o,
  output logic [31:0]          alu_imm_o,
  input  logic [31:0]          alu_result_i
);

  // Response slot state
  logic [1:0]         resp_valid_q, resp_valid_d;
  logic [63:0]        resp_result_q, resp_result_d;
  logic [2*TAG_W-1:0] resp_tag_q, resp_tag_d;

  logic [1:0] eligible;
  logic [1:0] grant;
  logic       prio;  // requester favoured on contention

  // A slot being drained this cycle can take a new result at the same edge.
  assign eligible = req_valid_i & (~resp_valid_q | resp_ready_i);

  // Grant is forced to zero while reset is asserted so nothing reaches the ALU.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready_o = grant;

  // ALU operand mux
  always_comb begin
    alu_instr_o = '0;
    alu_rs1_v_o = '0;
    alu_rs2_v_o = '0;
    alu_imm_o   = '0;
    unique case (grant)
      2'b01: begin
        alu_instr_o = req_instr_i[0 +: INSTR_W];
        alu_rs1_v_o = req_rs1_v_i[31:0];
        alu_rs2_v_o = req_rs2_v_i[31:0];
        alu_imm_o   = req_imm_i[31:0];
      end
      2'b10: begin
        alu_instr_o = req_instr_i[INSTR_W +: INSTR_W];
        alu_rs1_v_o = req_rs1_v_i[63:32];
        alu_rs2_v_o = req_rs2_v_i[63:32];
        alu_imm_o   = req_imm_i[63:32];
      end
      default: ;
    endcase
  end

  // Response slot next state: capture on grant, clear on drain, otherwise hold.
  // Result and tag are left untouched on a plain drain.
  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_tag_d    = resp_tag_q;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        resp_valid_d[i]                = 1'b1;
        resp_result_d[i*32 +: 32]      = alu_result_i;
        resp_tag_d[i*TAG_W +: TAG_W]   = req_tag_i[i*TAG_W +: TAG_W];
      end else if (resp_ready_i[i]) begin
        resp_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_tag_q    <= '0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_tag_q    <= resp_tag_d;
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_result_o = resp_result_q;
  assign resp_tag_o    = resp_tag_q;

`ifdef ALU_ARBITER_RR_EN
  // After any grant the other requester is favoured next time both contend.
  logic prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (grant[0]) begin
      prio_d = 1'b1;
    end else if (grant[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio = prio_q;
`else
  // Fixed priority: requester 0 wins every contention.
  assign prio = 1'b0;
`endif

  // Grant must never select both requesters.
  grant_onehot0_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

  // A granted requester must have had room in its response slot.
  grant_room_a: assert property (@(posedge clk) disable iff (rst)
    (grant & ~eligible) == 2'b00);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. Provides a small combinational ALU model and checks
// grants, captured results, backpressure and reset behaviour against hand-computed values.

module tb_alu_arbiter;

  localparam int unsigned TAG_W   = 4;
  localparam int unsigned INSTR_W = 8;

  // One-hot instruction encodings used by the ALU model
  localparam logic [INSTR_W-1:0] OpAdd  = 8'h01;
  localparam logic [INSTR_W-1:0] OpSub  = 8'h02;
  localparam logic [INSTR_W-1:0] OpAddi = 8'h04;
  localparam logic [INSTR_W-1:0] OpLw   = 8'h08;

  logic                 clk;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*INSTR_W-1:0] req_instr;
  logic [63:0]          req_rs1_v;
  logic [63:0]          req_rs2_v;
  logic [63:0]          req_imm;
  logic [2*TAG_W-1:0]   req_tag;
  logic [1:0]           resp_valid;
  logic [1:0]           resp_ready;
  logic [63:0]          resp_result;
  logic [2*TAG_W-1:0]   resp_tag;
  logic [INSTR_W-1:0]   alu_instr;
  logic [31:0]          alu_rs1_v;
  logic [31:0]          alu_rs2_v;
  logic [31:0]          alu_imm;
  logic [31:0]          alu_result;

  int n_cmp;
  int n_err;

  alu_arbiter #(
    .TAG_W   (TAG_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_instr_i   (req_instr),
    .req_rs1_v_i   (req_rs1_v),
    .req_rs2_v_i   (req_rs2_v),
    .req_imm_i     (req_imm),
    .req_tag_i     (req_tag),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_result_o (resp_result),
    .resp_tag_o    (resp_tag),
    .alu_instr_o   (alu_instr),
    .alu_rs1_v_o   (alu_rs1_v),
    .alu_rs2_v_o   (alu_rs2_v),
    .alu_imm_o     (alu_imm),
    .alu_result_i  (alu_result)
  );

  // Combinational ALU model
  always_comb begin
    alu_result = '0;
    case (alu_instr)
      OpAdd:   alu_result = alu_rs1_v + alu_rs2_v;
      OpSub:   alu_result = alu_rs1_v - alu_rs2_v;
      OpAddi:  alu_result = alu_rs1_v + alu_imm;
      OpLw:    alu_result = alu_rs1_v + alu_imm;
      default: alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [INSTR_W-1:0] instr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [TAG_W-1:0] tag);
    req_instr[i*INSTR_W +: INSTR_W] = instr;
    req_rs1_v[i*32 +: 32]           = rs1;
    req_rs2_v[i*32 +: 32]           = rs2;
    req_imm[i*32 +: 32]             = imm;
    req_tag[i*TAG_W +: TAG_W]       = tag;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    req_instr  = '0;
    req_rs1_v  = '0;
    req_rs2_v  = '0;
    req_imm    = '0;
    req_tag    = '0;

    // Reset with both requesters valid
    set_req(0, OpAdd, 32'd1, 32'd2, 32'd0, 4'd1);
    set_req(1, OpAdd, 32'd3, 32'd4, 32'd0, 4'd3);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_result", resp_result, 64'h0);
    check("rst_resp_tag", 64'(resp_tag), 64'h0);
    check("rst_alu_instr", 64'(alu_instr), 64'h0);

    rst = 1'b0;
    #1;
    check("first_grant", 64'(req_ready), 64'h1);
    check("first_alu_rs1", 64'(alu_rs1_v), 64'd1);
    tick();
    req_valid = 2'b00;
    check("first_resp_valid", 64'(resp_valid), 64'h1);
    check("first_result", 64'(resp_result[31:0]), 64'd3);
    check("first_tag", 64'(resp_tag[3:0]), 64'd1);
    tick();
    check("drain_valid", 64'(resp_valid), 64'h0);
    check("drain_result_held", 64'(resp_result[31:0]), 64'd3);
    check("idle_alu_instr", 64'(alu_instr), 64'h0);

    // Single addi: 5 + (-3) = 2
    set_req(0, OpAddi, 32'd5, 32'd0, 32'hFFFF_FFFD, 4'd2);
    req_valid = 2'b01;
    #1;
    check("addi_ready", 64'(req_ready), 64'h1);
    check("addi_alu_instr", 64'(alu_instr), 64'(OpAddi));
    tick();
    req_valid = 2'b00;
    check("addi_resp_valid", 64'(resp_valid), 64'h1);
    check("addi_result", 64'(resp_result[31:0]), 64'd2);
    check("addi_tag", 64'(resp_tag[3:0]), 64'd2);
    #1;
    check("addi_idle_alu", 64'(alu_instr), 64'h0);

    // Short reset pulse so contention starts from prio = 0
    rst = 1'b1;
    #1;
    rst = 1'b0;

    // Contention for four cycles
    set_req(0, OpAdd, 32'd10, 32'd20, 32'd0, 4'd4);
    set_req(1, OpLw, 32'h100, 32'd0, 32'd8, 4'd5);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef ALU_ARBITER_RR_EN
      check("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
`else
      check("fixed_grant", 64'(req_ready), 64'h1);
`endif
      tick();
`ifdef ALU_ARBITER_RR_EN
      if (k % 2 == 1) begin
        check("rr_lw_result", 64'(resp_result[63:32]), 64'h108);
        check("rr_lw_tag", 64'(resp_tag[7:4]), 64'd5);
      end else begin
        check("rr_add_result", 64'(resp_result[31:0]), 64'd30);
      end
`else
      check("fixed_add_result", 64'(resp_result[31:0]), 64'd30);
      check("fixed_r1_idle", 64'(resp_valid[1]), 64'h0);
`endif
    end
    req_valid = 2'b00;
    tick();
    check("cont_drained", 64'(resp_valid), 64'h0);

    // Backpressure on requester 0
    resp_ready = 2'b10;
    set_req(0, OpAdd, 32'd7, 32'd8, 32'd0, 4'd6);
    req_valid = 2'b01;
    #1;
    check("bp_fill_ready", 64'(req_ready), 64'h1);
    tick();
    check("bp_full_valid", 64'(resp_valid), 64'h1);
    check("bp_full_result", 64'(resp_result[31:0]), 64'd15);
    set_req(0, OpSub, 32'd9, 32'd4, 32'd0, 4'd7);
    set_req(1, OpAdd, 32'd100, 32'd1, 32'd0, 4'd8);
    req_valid = 2'b11;
    #1;
    check("bp_ready", 64'(req_ready), 64'h2);
    tick();
    check("bp_both_valid", 64'(resp_valid), 64'h3);
    check("bp_result0_held", 64'(resp_result[31:0]), 64'd15);
    check("bp_tag0_held", 64'(resp_tag[3:0]), 64'd6);
    check("bp_result1", 64'(resp_result[63:32]), 64'd101);
    req_valid  = 2'b01;
    resp_ready = 2'b11;
    #1;
    check("refill_ready", 64'(req_ready), 64'h1);
    tick();
    check("refill_valid", 64'(resp_valid), 64'h1);
    check("refill_result", 64'(resp_result[31:0]), 64'd5);
    check("refill_tag", 64'(resp_tag[3:0]), 64'd7);

    // Fill both slots, last grant to requester 0, then reset mid-stream
    resp_ready = 2'b00;
    set_req(1, OpAdd, 32'd2, 32'd3, 32'd0, 4'd9);
    req_valid = 2'b10;
    tick();
    check("ms_fill1_valid", 64'(resp_valid), 64'h3);
    resp_ready = 2'b01;
    set_req(0, OpAdd, 32'd1, 32'd1, 32'd0, 4'd10);
    req_valid = 2'b01;
    tick();
    check("ms_fill0_result", 64'(resp_result[31:0]), 64'd2);
    check("ms_fill0_valid", 64'(resp_valid), 64'h3);
    resp_ready = 2'b00;
    req_valid  = 2'b11;
    #1;
    check("ms_full_ready", 64'(req_ready), 64'h0);
    rst = 1'b1;
    #1;
    check("ms_rst_valid", 64'(resp_valid), 64'h0);
    check("ms_rst_result", resp_result, 64'h0);
    check("ms_rst_ready", 64'(req_ready), 64'h0);
    check("ms_rst_alu", 64'(alu_instr), 64'h0);
    tick();
    rst        = 1'b0;
    resp_ready = 2'b11;
    #1;
    check("ms_post_prio", 64'(req_ready), 64'h1);
    tick();
    check("ms_post_valid", 64'(resp_valid), 64'h1);
    check("ms_post_result", 64'(resp_result[31:0]), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters: requester 0 is the execute stage and requester 1 is the load/store address generator. Each requester gets a valid/ready request channel and a valid/ready response channel. The block grants at most one request per cycle, drives that request's operands onto the ALU, and captures the ALU result into a per-requester one-entry response register. It sits between decode/issue and writeback and is the only driver of the `alu` inputs.

## Interface
- TAG_W, 4: width of the opaque tag returned with each result.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid; index 0 = execute, index 1 = AGU.
- req_ready  output  2  per-requester request accepted this cycle.
- req_instr  input  2 x instructions  decoded one-hot instruction struct, one per requester.
- req_rs1_v, req_rs2_v, req_imm  input  2 x 32 each  operands per requester.
- req_tag  input  2 x TAG_W  tag per requester.
- resp_valid  output  2  response register holds a result.
- resp_ready  input  2  consumer takes the response this cycle.
- resp_result  output  2 x 32  captured ALU result.
- resp_tag  output  2 x TAG_W  tag of the captured result.
- alu_instr  output  instructions  to `alu.instr`; all-zero when there is no grant.
- alu_rs1_v, alu_rs2_v, alu_imm  output  32 each  to `alu`; zero when there is no grant.
- alu_result  input  32  from `alu.result`, combinational in the same cycle.

## Operation
- Slot state: full[i] is 1 while resp_valid[i] is 1.
- eligible[i] = req_valid[i] && (!full[i] || resp_ready[i]). A slot being drained can be refilled in the same cycle.
- Grant is combinational and one-hot or zero:
  - If only one requester is eligible, it is granted.
  - If both are eligible, the pointer `prio` chooses the winner.
- req_ready[i] = grant[i]. A request is accepted on req_valid[i] && req_ready[i].
- When grant[i] is 1, alu_* outputs come from requester i's payload. The response register for i loads alu_result and req_tag[i] at the clock edge, and resp_valid[i] is set to 1.
- Drain without refill: resp_valid[i] clears to 0, and resp_result/resp_tag hold their old value.
- Requester rules: the payload stays stable while req_valid is 1 and req_ready is 0. req_valid stays high until the request is accepted.
- Responder rule: resp_valid/result/tag stay stable until resp_ready is 1.
- A non-granted requester is unaffected: no state change, and its ready is 0.

## Timing
- Latency: accept in cycle N, then resp_valid in cycle N+1. Accept and result capture happen in one cycle.
- Throughput: one grant per cycle in total. Each requester sustains 1/cycle while its consumer holds resp_ready=1 and it is the only eligible requester.
- Reset values (async assert, synchronous-release safe):
  - resp_valid = 0, resp_result = 0, resp_tag = 0, prio = 0.
  - req_ready = 0 and alu_* = 0 during reset.
- Reset asserted mid-operation discards both response slots. The in-flight grant of that cycle is lost, and the requester must re-present it.
- Full slot with resp_ready=0: that requester's ready is held at 0. The other requester can still be granted. There is no head-of-line blocking across requesters.

## Configuration
- ALU_ARBITER_RR_EN defined: round-robin arbitration.
  - On a contended grant to i, prio becomes 1-i.
  - On an uncontested grant, prio becomes 1-(granted index), so the next contention favours the other requester.
- ALU_ARBITER_RR_EN undefined: fixed priority. Requester 0 wins every contention, and the prio register is absent (held at 0).

## Test plan
- Reset: assert rst with both req_valid=1. Require req_ready=00, resp_valid=00, resp_result=0. After release, the first grant goes to requester 0.
- Single addi: requester 0 sends addi, rs1=5, imm=-3, tag=2, with resp_ready=1. Require resp_valid[0]=1 next cycle with result=2 and tag=2, and alu_instr all-zero in idle cycles.
- Contention with RR enabled: both requesters valid for 4 cycles, resp_ready=11. Require grants 0,1,0,1, with lw on requester 1 (rs1=0x100, imm=8) returning 0x108.
- Contention with RR disabled: same stimulus. Require requester 0 granted every cycle and req_ready[1]=0 throughout.
- Backpressure: requester 0 slot full with resp_ready[0]=0 and a new request pending. Require req_ready[0]=0, resp_result held, and requester 1 granted. Raising resp_ready[0] gives drain and refill in the same cycle, so resp_valid[0] stays 1 with the new result.
- Mid-stream reset: assert rst while both slots are full. Require both resp_valid=0 immediately (asynchronous) and prio=0.
